// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and memory-wait hazard controller with watchdog
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   EnRs1_id/EnRs2_id        ID instruction reads rs1/rs2
//   Rs1Idx_id/Rs2Idx_id      ID source indices
//   EnMemR_ex/RdIdx_ex       EX instruction is a load / its destination
//   Redirect_ex              taken branch/jump resolved in EX
//   MemReq_mem/MemReady_mem  MEM access request / completion
//   Stall_*/Flush_id/Bubble_* pipeline control (combinational)
//   Err_timeout              sticky memory watchdog error
//   PerfLu/PerfMem/PerfFlush saturating event counters (only with HAZARD_PERF_EN)
module hazard_ctrl #(
    parameter int RF_SIZE     = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               EnRs1_id,
    input  logic               EnRs2_id,
    input  logic [RF_SIZE-1:0] Rs1Idx_id,
    input  logic [RF_SIZE-1:0] Rs2Idx_id,
    input  logic               EnMemR_ex,
    input  logic [RF_SIZE-1:0] RdIdx_ex,
    input  logic               Redirect_ex,
    input  logic               MemReq_mem,
    input  logic               MemReady_mem,
    output logic               Stall_if,
    output logic               Stall_id,
    output logic               Stall_ex,
    output logic               Stall_mem,
    output logic               Flush_id,
    output logic               Bubble_ex,
    output logic               Bubble_wb,
    output logic               Err_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        PerfLu,
    output logic [31:0]        PerfMem,
    output logic [31:0]        PerfFlush
`endif
);
    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             lu, mb, lu_g, fl_g;

    assign lu = EnMemR_ex && RdIdx_ex != '0 &&
                ((EnRs1_id && Rs1Idx_id == RdIdx_ex) || (EnRs2_id && Rs2Idx_id == RdIdx_ex));
    assign mb = MemReq_mem && !MemReady_mem;
    // A frozen pipeline outranks a redirect, which in turn squashes any load-use stall.
    assign fl_g = !mb && Redirect_ex;
    assign lu_g = !mb && !Redirect_ex && lu;

    assign Stall_if    = mb || lu_g;
    assign Stall_id    = mb || lu_g;
    assign Stall_ex    = mb;
    assign Stall_mem   = mb;
    assign Bubble_wb   = mb;
    assign Flush_id    = fl_g;
    assign Bubble_ex   = fl_g || lu_g;
    assign Err_timeout = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // The error is taken from the registered count, one edge after it hits the limit.
        err_d   = err_q || cnt_q == CNT_W'(MEM_TIMEOUT);
        case (state_q)
            S_RUN: begin
                state_d = mb ? S_WAIT : S_RUN;
                cnt_d   = mb ? CNT_W'(1) : '0;
            end
            default: begin
                state_d = mb ? S_WAIT : S_RUN;
                cnt_d   = !mb ? '0 : &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_q, perf_mem_q, perf_fl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_q  <= '0;
            perf_mem_q <= '0;
            perf_fl_q  <= '0;
        end else begin
            perf_lu_q  <= perf_lu_q  + {31'b0, lu_g && !(&perf_lu_q)};
            perf_mem_q <= perf_mem_q + {31'b0, mb   && !(&perf_mem_q)};
            perf_fl_q  <= perf_fl_q  + {31'b0, fl_g && !(&perf_fl_q)};
        end
    end

    assign PerfLu    = perf_lu_q;
    assign PerfMem   = perf_mem_q;
    assign PerfFlush = perf_fl_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, directed corner sequences and random checks against a model
module tb_hazard_ctrl;
    localparam int T = 4;

    logic       clk = 1'b0, rst = 1'b0;
    logic       e1, e2, memr, redir, req, rdy;
    logic [4:0] r1, r2, rd;
    logic       s_if, s_id, s_ex, s_mem, fl_id, b_ex, b_wb, err;
    logic [6:0] outv;
    int         n_run = 0, n_fail = 0;
    int         m_cnt, m_lu, m_mem, m_fl;
    logic       m_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] p_lu, p_mem, p_fl;
`endif

    hazard_ctrl #(.RF_SIZE(5), .MEM_TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .EnRs1_id(e1), .EnRs2_id(e2), .Rs1Idx_id(r1), .Rs2Idx_id(r2),
        .EnMemR_ex(memr), .RdIdx_ex(rd), .Redirect_ex(redir),
        .MemReq_mem(req), .MemReady_mem(rdy),
        .Stall_if(s_if), .Stall_id(s_id), .Stall_ex(s_ex), .Stall_mem(s_mem),
        .Flush_id(fl_id), .Bubble_ex(b_ex), .Bubble_wb(b_wb), .Err_timeout(err)
`ifdef HAZARD_PERF_EN
        , .PerfLu(p_lu), .PerfMem(p_mem), .PerfFlush(p_fl)
`endif
    );

    always #5 clk = ~clk;

    assign outv = {s_if, s_id, s_ex, s_mem, fl_id, b_ex, b_wb};

    // Expected control word {if,id,ex,mem,flush,bub_ex,bub_wb} from the priority rules.
    function automatic logic [6:0] model_out();
        logic hz;
        hz = memr && rd != 0 && ((e1 && r1 == rd) || (e2 && r2 == rd));
        if (req && !rdy) return 7'b1111001;
        if (redir)       return 7'b0000110;
        if (hz)          return 7'b1100010;
        return 7'b0000000;
    endfunction

    // Watchdog and event-count model: wait length in cycles, error once it has reached T.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_err <= 1'b0; m_lu <= 0; m_mem <= 0; m_fl <= 0;
        end else begin
            m_err <= m_err || m_cnt == T;
            m_cnt <= (req && !rdy) ? (m_cnt < 65535 ? m_cnt + 1 : m_cnt) : 0;
            if (model_out() == 7'b1111001) m_mem <= m_mem + 1;
            else if (model_out() == 7'b0000110) m_fl <= m_fl + 1;
            else if (model_out() == 7'b1100010) m_lu <= m_lu + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a1, input logic a2, input logic [4:0] i1, input logic [4:0] i2,
                         input logic ml, input logic [4:0] d, input logic rr, input logic q,
                         input logic y);
        @(negedge clk);
        e1 = a1; e2 = a2; r1 = i1; r2 = i2; memr = ml; rd = d; redir = rr; req = q; rdy = y;
        #1;
    endtask

    typedef struct {
        logic       a1, a2;
        logic [4:0] i1, i2;
        logic       ml;
        logic [4:0] d;
        logic       rr, q, y;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0, 5, 0, 1, 5, 0, 0, 0, 7'b1100010};
        tbl[1] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 7'b0000000};
        tbl[2] = '{0, 1, 0, 7, 1, 7, 1, 0, 0, 7'b0000110};
        tbl[3] = '{0, 0, 5, 5, 1, 5, 0, 0, 0, 7'b0000000};
        tbl[4] = '{1, 0, 5, 0, 0, 5, 0, 0, 0, 7'b0000000};
        tbl[5] = '{0, 1, 0, 9, 1, 9, 0, 1, 1, 7'b1100010};
        tbl[6] = '{1, 1, 3, 3, 1, 3, 1, 1, 0, 7'b1111001};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000};
        tbl[8] = '{1, 1, 3, 4, 1, 6, 0, 1, 1, 7'b0000000};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000110};

        {e1, e2, memr, redir, req, rdy} = '0; r1 = 0; r2 = 0; rd = 0;
        #2 rst = 1'b1;
        #10;
        chk("reset_out", {25'b0, outv}, 0);
        chk("reset_err", {31'b0, err}, 0);
        @(negedge clk) rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].a1, tbl[i].a2, tbl[i].i1, tbl[i].i2, tbl[i].ml, tbl[i].d,
                  tbl[i].rr, tbl[i].q, tbl[i].y);
            chk($sformatf("table%0d", i), {25'b0, outv}, {25'b0, tbl[i].exp});
        end

        // load-use lasts one cycle: the load moves on to MEM
        drive(1, 0, 5, 0, 1, 5, 0, 0, 0);
        chk("lu_cycle", {25'b0, outv}, 7'b1100010);
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
        chk("lu_after", {25'b0, outv}, 0);

        // three-cycle memory wait with a redirect frozen in EX
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
            chk($sformatf("memwait%0d", i), {25'b0, outv}, 7'b1111001);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("release_flush", {25'b0, outv}, 7'b0000110);
        chk("release_err", {31'b0, err}, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle", {25'b0, outv}, 0);

        // watchdog: count reaches T after the 4th wait cycle, error visible from the 6th
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("wd_err%0d", i), {31'b0, err}, {31'b0, i == 6});
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("wd_sticky_ready", {31'b0, err}, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wd_sticky_idle", {31'b0, err}, 1);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 rst = 1'b1;
        #1 chk("async_rst_err", {31'b0, err}, 0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("wd_restart%0d", i), {31'b0, err}, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("wd_restart_set", {31'b0, err}, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic on a narrow register range to provoke matches
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0);
            chk("rnd_out", {25'b0, outv}, {25'b0, model_out()});
            chk("rnd_err", {31'b0, err}, {31'b0, m_err});
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
`ifdef HAZARD_PERF_EN
        #1;
        chk("perf_lu", p_lu, m_lu);
        chk("perf_mem", p_mem, m_mem);
        chk("perf_flush", p_fl, m_fl);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
